// File: rtl/i2c_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : i2c_pkg
// Description : Shared definitions for the I2C temperature-sensor target.
//               Holds the protocol FSM state encoding, the register-pointer
//               map and the read-data multiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

  // Protocol FSM states
  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_ACK  = 4'd2,
    PTR       = 4'd3,
    PTR_ACK   = 4'd4,
    WDATA     = 4'd5,
    WDATA_ACK = 4'd6,
    RDATA     = 4'd7,
    RD_MACK   = 4'd8
  } state_t;

  // Register pointer map
  localparam logic [7:0] PTR_TEMP_MSB = 8'h00;
  localparam logic [7:0] PTR_TEMP_LSB = 8'h01;
  localparam logic [7:0] PTR_CFG      = 8'h03;
  localparam logic [7:0] PTR_ID       = 8'h0B;

  // Value returned for a read at the given pointer; unmapped pointers read 0.
  function automatic logic [7:0] reg_read(
    input logic [7:0]  ptr,
    input logic [15:0] snap,
    input logic [7:0]  cfg,
    input logic [7:0]  id
  );
    case (ptr)
      PTR_TEMP_MSB: reg_read = snap[15:8];
      PTR_TEMP_LSB: reg_read = snap[7:0];
      PTR_CFG:      reg_read = cfg;
      PTR_ID:       reg_read = id;
      default:      reg_read = 8'h00;
    endcase
  endfunction

endpackage : i2c_pkg
`default_nettype wire

// File: rtl/i2c_bus_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : i2c_bus_sync
// Description : Two-flop synchronisers for raw SCL/SDA plus detection of
//               SCL edges and START/STOP conditions on the synchronised bus.
// Ports       : i_clk, i_rst_n (async active-low), i_scl, i_sda (raw bus),
//               o_sda (synchronised SDA), o_scl_rise, o_scl_fall,
//               o_start, o_stop (single-cycle pulses)
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_bus_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  logic r_scl_meta, r_scl_sync, r_scl_prev;
  logic r_sda_meta, r_sda_sync, r_sda_prev;

  // Idle bus level is high, so everything resets to 1 to avoid false edges.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_scl_meta <= 1'b1;
      r_scl_sync <= 1'b1;
      r_scl_prev <= 1'b1;
      r_sda_meta <= 1'b1;
      r_sda_sync <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_meta <= i_scl;
      r_scl_sync <= r_scl_meta;
      r_scl_prev <= r_scl_sync;
      r_sda_meta <= i_sda;
      r_sda_sync <= r_sda_meta;
      r_sda_prev <= r_sda_sync;
    end
  end

  assign o_sda      = r_sda_sync;
  assign o_scl_rise = r_scl_sync & ~r_scl_prev;
  assign o_scl_fall = ~r_scl_sync & r_scl_prev;
  // SDA transitions only count as conditions while SCL is stable high.
  assign o_start    = r_scl_sync & r_scl_prev & r_sda_prev & ~r_sda_sync;
  assign o_stop     = r_scl_sync & r_scl_prev & ~r_sda_prev & r_sda_sync;

endmodule : i2c_bus_sync
`default_nettype wire

// File: rtl/i2c_temp_target.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : i2c_temp_target
// Description : I2C target for a temperature sensor. Register pointer map:
//               00 temp MSB, 01 temp LSB, 03 config, 0B ID. The temperature
//               word is snapshotted at address match so a multi-byte read
//               is coherent. Build option I2C_TGT_WRITE_EN enables writes of
//               data bytes after the pointer byte (config at pointer 03);
//               without it those bytes are NACKed and cfg_reg reads 00.
// Ports       : CLK100MHZ     system clock
//               reset         asynchronous active-low reset
//               scl_i, sda_i  raw bus inputs
//               sda_drive_low open-drain SDA pull-down request
//               temp_in       16-bit temperature word
//               cfg_reg       configuration register
//               rd_strobe     pulse when a pointer-00 byte has been sent
//               busy          addressed transaction in progress
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_temp_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h4B,
  parameter logic [7:0] ID_VAL   = 8'hCB
) (
  input  logic        CLK100MHZ,
  input  logic        reset,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_drive_low,
  input  logic [15:0] temp_in,
  output logic [7:0]  cfg_reg,
  output logic        rd_strobe,
  output logic        busy
);

  logic        w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0]  w_byte;
  logic [7:0]  w_rd_data;

  state_t      r_state;
  logic [2:0]  r_bitcnt;
  logic [7:0]  r_shift;
  logic [7:0]  r_tx;
  logic [7:0]  r_ptr;
  logic [15:0] r_snap;
  logic        r_rw;
  logic        r_phase;   // ACK states: 0 = ACK not yet driven, 1 = driving
  logic        r_sda_drv;
  logic        r_rd_strobe;
  logic        r_busy;

  i2c_bus_sync u_sync (
    .i_clk      (CLK100MHZ),
    .i_rst_n    (reset),
    .i_scl      (scl_i),
    .i_sda      (sda_i),
    .o_sda      (w_sda),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );

`ifdef I2C_TGT_WRITE_EN
  logic [7:0] r_cfg;
  assign cfg_reg = r_cfg;
`else
  assign cfg_reg = 8'h00;
`endif

  // Byte as it stands including the bit being sampled on this SCL rise
  assign w_byte    = {r_shift[6:0], w_sda};
  assign w_rd_data = reg_read(r_ptr, r_snap, cfg_reg, ID_VAL);

  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_bitcnt    <= 3'd0;
      r_shift     <= 8'h00;
      r_tx        <= 8'h00;
      r_ptr       <= 8'h00;
      r_snap      <= 16'h0000;
      r_rw        <= 1'b0;
      r_phase     <= 1'b0;
      r_sda_drv   <= 1'b0;
      r_rd_strobe <= 1'b0;
      r_busy      <= 1'b0;
`ifdef I2C_TGT_WRITE_EN
      r_cfg       <= 8'h00;
`endif
    end else begin
      r_rd_strobe <= 1'b0;
      if (w_stop) begin
        r_state   <= IDLE;
        r_sda_drv <= 1'b0;
        r_busy    <= 1'b0;
      end else if (w_start) begin
        // Also covers repeated START from any state
        r_state   <= ADDR;
        r_bitcnt  <= 3'd0;
        r_phase   <= 1'b0;
        r_sda_drv <= 1'b0;
        r_busy    <= 1'b0;
      end else begin
        case (r_state)
          IDLE: ;

          ADDR: if (w_scl_rise) begin
            r_shift  <= w_byte;
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              if (w_byte[7:1] == DEV_ADDR) begin
                r_snap  <= temp_in;
                r_rw    <= w_byte[0];
                r_busy  <= 1'b1;
                r_phase <= 1'b0;
                r_state <= ADDR_ACK;
              end else begin
                r_sda_drv <= 1'b0;
                r_state   <= IDLE;
              end
            end
          end

          ADDR_ACK: if (w_scl_fall) begin
            if (!r_phase) begin
              r_sda_drv <= 1'b1;
              r_phase   <= 1'b1;
            end else begin
              r_phase  <= 1'b0;
              r_bitcnt <= 3'd0;
              if (r_rw) begin
                // First read bit goes out on the fall that ends the ACK
                r_tx      <= w_rd_data;
                r_sda_drv <= ~w_rd_data[7];
                r_state   <= RDATA;
              end else begin
                r_sda_drv <= 1'b0;
                r_state   <= PTR;
              end
            end
          end

          PTR: if (w_scl_rise) begin
            r_shift  <= w_byte;
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              r_ptr   <= w_byte;
              r_phase <= 1'b0;
              r_state <= PTR_ACK;
            end
          end

          PTR_ACK: if (w_scl_fall) begin
            if (!r_phase) begin
              r_sda_drv <= 1'b1;
              r_phase   <= 1'b1;
            end else begin
              r_sda_drv <= 1'b0;
              r_phase   <= 1'b0;
              r_bitcnt  <= 3'd0;
              r_state   <= WDATA;
            end
          end

          WDATA: if (w_scl_rise) begin
            r_shift  <= w_byte;
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              r_phase <= 1'b0;
              r_state <= WDATA_ACK;
`ifdef I2C_TGT_WRITE_EN
              if (r_ptr == PTR_CFG) begin
                r_cfg <= w_byte;
              end
              r_ptr <= r_ptr + 8'd1;
`endif
            end
          end

          WDATA_ACK: if (w_scl_fall) begin
`ifdef I2C_TGT_WRITE_EN
            if (!r_phase) begin
              r_sda_drv <= 1'b1;
              r_phase   <= 1'b1;
            end else begin
              r_sda_drv <= 1'b0;
              r_phase   <= 1'b0;
              r_bitcnt  <= 3'd0;
              r_state   <= WDATA;
            end
`else
            // Leave SDA released through the ACK slot: the master sees NACK
            r_sda_drv <= 1'b0;
            r_state   <= IDLE;
`endif
          end

          RDATA: if (w_scl_fall) begin
            if (r_bitcnt == 3'd7) begin
              // Fall after bit 0: hand SDA to the master for its ACK/NACK
              r_sda_drv <= 1'b0;
              r_phase   <= 1'b0;
              r_state   <= RD_MACK;
              r_ptr     <= r_ptr + 8'd1;
              if (r_ptr == PTR_TEMP_MSB) begin
                r_rd_strobe <= 1'b1;
              end
            end else begin
              r_bitcnt  <= r_bitcnt + 3'd1;
              r_tx      <= {r_tx[6:0], 1'b0};
              r_sda_drv <= ~r_tx[6];
            end
          end

          RD_MACK: begin
            if (w_scl_rise && !r_phase) begin
              if (!w_sda) begin
                r_phase <= 1'b1;
              end else begin
                r_sda_drv <= 1'b0;
                r_state   <= IDLE;
              end
            end else if (w_scl_fall && r_phase) begin
              r_phase   <= 1'b0;
              r_bitcnt  <= 3'd0;
              r_tx      <= w_rd_data;
              r_sda_drv <= ~w_rd_data[7];
              r_state   <= RDATA;
            end
          end

          default: begin
            r_sda_drv <= 1'b0;
            r_state   <= IDLE;
          end
        endcase
      end
    end
  end

  assign sda_drive_low = r_sda_drv;
  assign rd_strobe     = r_rd_strobe;
  assign busy          = r_busy;

endmodule : i2c_temp_target
`default_nettype wire

// File: tb/tb_i2c_temp_target.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_i2c_temp_target
// Description : Self-checking bench for i2c_temp_target. Drives an I2C
//               master with a wired-AND SDA model and checks read data,
//               ACK/NACK, pointer behaviour, coherence, writes (both builds
//               of I2C_TGT_WRITE_EN) and reset in the middle of a read.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_temp_target;

  localparam int Q = 10;  // clock cycles per quarter SCL period

`ifdef I2C_TGT_WRITE_EN
  localparam logic WR_EN = 1'b1;
`else
  localparam logic WR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        scl_m;
  logic        sda_m;
  logic        sda_line;
  logic        sda_drive_low;
  logic [15:0] temp_in;
  logic [7:0]  cfg_reg;
  logic        rd_strobe;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign sda_line = sda_m & ~sda_drive_low;

  i2c_temp_target dut (
    .CLK100MHZ     (clk),
    .reset         (reset),
    .scl_i         (scl_m),
    .sda_i         (sda_line),
    .sda_drive_low (sda_drive_low),
    .temp_in       (temp_in),
    .cfg_reg       (cfg_reg),
    .rd_strobe     (rd_strobe),
    .busy          (busy)
  );

  // Bus monitors: counters only grow, the test reads deltas
  int   strobe_cnt = 0;
  int   drv_cycles = 0;
  int   busy_cycles = 0;
  int   hi_changes = 0;
  logic prev_drv = 1'b0;

  always @(negedge clk) begin
    prev_drv <= sda_drive_low;
    if (rd_strobe)     strobe_cnt  <= strobe_cnt + 1;
    if (sda_drive_low) drv_cycles  <= drv_cycles + 1;
    if (busy)          busy_cycles <= busy_cycles + 1;
    if (reset && scl_m && (sda_drive_low !== prev_drv)) hi_changes <= hi_changes + 1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic qwait();
    repeat (Q) @(posedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; qwait();
    scl_m = 1'b1; qwait();
    sda_m = 1'b0; qwait();
    scl_m = 1'b0; qwait();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; qwait();
    scl_m = 1'b1; qwait();
    sda_m = 1'b1; qwait();
  endtask

  task automatic wbit(input logic b);
    sda_m = b;    qwait();
    scl_m = 1'b1; qwait(); qwait();
    scl_m = 1'b0; qwait();
  endtask

  task automatic rbit(output logic b);
    sda_m = 1'b1; qwait();
    scl_m = 1'b1; qwait();
    b = sda_line; qwait();
    scl_m = 1'b0; qwait();
  endtask

  // ack = 1 when the target pulled SDA low in the ACK slot
  task automatic wbyte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(b);
    ack = ~b;
  endtask

  // mack = 1 to ACK the byte, 0 to NACK it
  task automatic rbyte(output logic [7:0] d, input logic mack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rbit(b);
      d[i] = b;
    end
    wbit(~mack);
  endtask

  typedef struct {
    logic [15:0] temp;
    logic [7:0]  ptr;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic       ack;
    logic       b;
    logic [7:0] d;
    int         s0, d0, b0;

    vecs[0] = '{16'h0C80, 8'h00, 8'h0C};
    vecs[1] = '{16'h0C80, 8'h01, 8'h80};
    vecs[2] = '{16'h1234, 8'h0B, 8'hCB};
    vecs[3] = '{16'h1234, 8'h03, 8'h00};
    vecs[4] = '{16'hABCD, 8'h02, 8'h00};
    vecs[5] = '{16'hABCD, 8'h01, 8'hCD};
    vecs[6] = '{16'h5A3C, 8'h00, 8'h5A};

    reset = 1'b0; scl_m = 1'b1; sda_m = 1'b1; temp_in = 16'h0000;
    repeat (5) @(posedge clk);
    #1;
    check("reset_sda_drive_low", {15'd0, sda_drive_low}, 16'd0);
    check("reset_busy",          {15'd0, busy},          16'd0);
    check("reset_cfg_reg",       {8'd0, cfg_reg},        16'd0);
    check("reset_rd_strobe",     {15'd0, rd_strobe},     16'd0);
    @(negedge clk);
    reset = 1'b1;
    qwait();

    // Table: write pointer, repeated START, read one byte
    for (int i = 0; i < 7; i++) begin
      temp_in = vecs[i].temp;
      i2c_start();
      wbyte(8'h96, ack); check($sformatf("vec%0d_addrw_ack", i), {15'd0, ack}, 16'd1);
      wbyte(vecs[i].ptr, ack); check($sformatf("vec%0d_ptr_ack", i), {15'd0, ack}, 16'd1);
      i2c_start();
      wbyte(8'h97, ack); check($sformatf("vec%0d_addrr_ack", i), {15'd0, ack}, 16'd1);
      rbyte(d, 1'b0);    check($sformatf("vec%0d_data", i), {8'd0, d}, {8'd0, vecs[i].exp});
      i2c_stop();
    end

    // Two-byte temperature read with single rd_strobe
    temp_in = 16'h0C80;
    s0 = strobe_cnt;
    i2c_start();
    wbyte(8'h96, ack); check("rd2_addrw_ack", {15'd0, ack}, 16'd1);
    check("rd2_busy_during", {15'd0, busy}, 16'd1);
    wbyte(8'h00, ack); check("rd2_ptr_ack", {15'd0, ack}, 16'd1);
    i2c_start();
    wbyte(8'h97, ack); check("rd2_addrr_ack", {15'd0, ack}, 16'd1);
    rbyte(d, 1'b1);    check("rd2_byte0", {8'd0, d}, 16'h000C);
    rbyte(d, 1'b0);    check("rd2_byte1", {8'd0, d}, 16'h0080);
    i2c_stop();
    qwait();
    check("rd2_busy_after", {15'd0, busy}, 16'd0);
    check("rd2_strobe_count", 16'(strobe_cnt - s0), 16'd1);

    // Address mismatch: never drive SDA, never busy
    d0 = drv_cycles; b0 = busy_cycles;
    i2c_start();
    wbyte(8'h90, ack); check("mismatch_ack", {15'd0, ack}, 16'd0);
    wbyte(8'h00, ack);
    i2c_stop();
    check("mismatch_drive", 16'(drv_cycles - d0), 16'd0);
    check("mismatch_busy",  16'(busy_cycles - b0), 16'd0);

    // Coherence: temp changes between MSB and LSB
    temp_in = 16'h0C80;
    i2c_start();
    wbyte(8'h96, ack);
    wbyte(8'h00, ack);
    i2c_start();
    wbyte(8'h97, ack);
    rbyte(d, 1'b1);    check("coh_msb", {8'd0, d}, 16'h000C);
    temp_in = 16'h0D10;
    rbyte(d, 1'b0);    check("coh_lsb", {8'd0, d}, 16'h0080);
    i2c_stop();

    // Pointer wrap FF->00, then retention across transactions (reads 01)
    temp_in = 16'h3C5A;
    i2c_start();
    wbyte(8'h96, ack);
    wbyte(8'hFF, ack);
    i2c_start();
    wbyte(8'h97, ack);
    rbyte(d, 1'b1);    check("wrap_ff", {8'd0, d}, 16'h0000);
    rbyte(d, 1'b0);    check("wrap_00", {8'd0, d}, 16'h003C);
    i2c_stop();
    i2c_start();
    wbyte(8'h97, ack); check("retain_addr_ack", {15'd0, ack}, 16'd1);
    rbyte(d, 1'b0);    check("retain_ptr01", {8'd0, d}, 16'h005A);
    i2c_stop();

    // Writes: config at 03, then a byte at 04 (ignored but ACKed if enabled)
    i2c_start();
    wbyte(8'h96, ack);
    wbyte(8'h03, ack); check("wr_ptr_ack", {15'd0, ack}, 16'd1);
    wbyte(8'hA5, ack); check("wr_cfg_ack", {15'd0, ack}, {15'd0, WR_EN});
    wbyte(8'h77, ack); check("wr_other_ack", {15'd0, ack}, {15'd0, WR_EN});
    i2c_stop();
    check("wr_cfg_reg", {8'd0, cfg_reg}, WR_EN ? 16'h00A5 : 16'h0000);
    i2c_start();
    wbyte(8'h96, ack);
    wbyte(8'h03, ack);
    i2c_start();
    wbyte(8'h97, ack);
    rbyte(d, 1'b0);    check("wr_cfg_readback", {8'd0, d}, WR_EN ? 16'h00A5 : 16'h0000);
    i2c_stop();

    // Reset in the middle of reading ID (CB): bit 4 is a 0, so SDA is driven
    i2c_start();
    wbyte(8'h96, ack);
    wbyte(8'h0B, ack);
    i2c_start();
    wbyte(8'h97, ack);
    rbit(b); rbit(b); rbit(b);
    check("rst_mid_drive_before", {15'd0, sda_drive_low}, 16'd1);
    reset = 1'b0;
    #1;
    check("rst_mid_drive_release", {15'd0, sda_drive_low}, 16'd0);
    check("rst_mid_busy", {15'd0, busy}, 16'd0);
    qwait();
    @(negedge clk);
    reset = 1'b1;
    sda_m = 1'b1; qwait();
    scl_m = 1'b1; qwait();
    temp_in = 16'h0C80;
    i2c_start();
    wbyte(8'h97, ack); check("rst_after_addr_ack", {15'd0, ack}, 16'd1);
    rbyte(d, 1'b0);    check("rst_after_ptr00", {8'd0, d}, 16'h000C);
    i2c_stop();
    check("rst_after_cfg", {8'd0, cfg_reg}, 16'd0);

    qwait();
    check("sda_change_while_scl_high", 16'(hi_changes), 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_i2c_temp_target
`default_nettype wire
